sync_fifo_stat: RTL and testbench
=================================

SYNC_FIFO_STAT -- requirements
Module: sync_fifo_stat

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which ALMOST_FULL asserts.
REQ-004 Parameter AE_LEVEL, default 2, occupancy at or below which ALMOST_EMPTY asserts.
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 W_INC  in  1  push request.
REQ-008 WR_DATA  in  DATA_WIDTH  data to push.
REQ-009 R_INC  in  1  pop request.
REQ-010 CLR_ERR  in  1  clears the sticky error flags.
REQ-011 RD_DATA  out  DATA_WIDTH  head-of-queue word, show-ahead.
REQ-012 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  out  1 each  status flags.
REQ-013 COUNT  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 OVERFLOW, UNDERFLOW  out  1 each  sticky error flags.

Function
REQ-015 Push acceptance: accepted iff W_INC=1 and FULL=0; an accepted push writes WR_DATA to mem[W_ADDR] and advances W_PTR by 1.
REQ-016 Pop acceptance: accepted iff R_INC=1 and EMPTY=0; an accepted pop advances R_PTR by 1.
REQ-017 W_PTR and R_PTR are $clog2(DEPTH)+1 bits wide; W_ADDR and R_ADDR are their low $clog2(DEPTH) bits; the MSB toggles on each wrap.
REQ-018 RD_DATA equals mem[R_ADDR] combinationally with zero-cycle latency; its value while EMPTY=1 is don't-care.
REQ-019 Flags and count are evaluated from pointer state before the edge, so:
  - push on FULL is rejected even with a simultaneous pop;
  - pop on EMPTY is rejected even with a simultaneous push.
REQ-020 Simultaneous accepted push and pop leaves COUNT unchanged and advances both pointers.
REQ-021 COUNT equals W_PTR - R_PTR, modulo 2^($clog2(DEPTH)+1).
REQ-022 FULL = (COUNT == DEPTH); EMPTY = (COUNT == 0).
REQ-023 ALMOST_FULL = (COUNT >= AF_LEVEL); ALMOST_EMPTY = (COUNT <= AE_LEVEL).
REQ-024 All flags are derived combinationally from registered pointers; they are glitch-free relative to CLK.
REQ-025 A rejected push or pop changes no pointer, memory word or count.

Reset
REQ-026 While RST=1 at a rising edge, the following reset to these values:
  - W_PTR, R_PTR, COUNT = 0;
  - EMPTY = 1 and ALMOST_EMPTY = 1;
  - FULL = 0 and ALMOST_FULL = 0;
  - OVERFLOW = 0 and UNDERFLOW = 0.
REQ-027 Memory contents are not reset.
REQ-028 RST has priority over W_INC, R_INC and CLR_ERR in the same cycle.
REQ-029 Reset asserted mid-stream discards all queued data.

Configuration
REQ-030 Macro SYNC_FIFO_ERR_EN, when defined, enables the sticky error flags:
  - OVERFLOW sets on a cycle with W_INC=1 and FULL=0 false (i.e. FULL=1);
  - UNDERFLOW sets on a cycle with R_INC=1 and EMPTY=1;
  - both clear on CLR_ERR=1;
  - a set event and CLR_ERR in the same cycle leaves the flag set.
REQ-031 Without SYNC_FIFO_ERR_EN, OVERFLOW and UNDERFLOW are tied to 0, CLR_ERR is ignored, and the ports remain present.

Structure
REQ-032 Package fifo_pkg holds the default DATA_WIDTH/DEPTH constants and a pointer-width helper ($clog2(DEPTH)+1).
REQ-033 Sub-module sync_fifo_mem: DEPTH x DATA_WIDTH storage with a registered write port and an asynchronous read port.
REQ-034 Pointer, count, flag and error logic reside in sync_fifo_stat.

Verification
REQ-035 Reset then 8 pushes of 0x01..0x08 with DEPTH=8 -> after the 8th push FULL=1, COUNT=8, ALMOST_FULL=1 since COUNT reached 6; RD_DATA=0x01 throughout.
REQ-036 From full, 8 pops -> RD_DATA sequence 0x01..0x08; EMPTY=1 and COUNT=0 after the last pop; ALMOST_EMPTY=1 from COUNT=2.
REQ-037 COUNT=4, W_INC=R_INC=1 for 20 cycles -> COUNT stays 4, both pointers wrap, data order preserved.
REQ-038 FULL, W_INC=1, R_INC=1 -> pop accepted, push rejected, COUNT=7; with SYNC_FIFO_ERR_EN, OVERFLOW=1 until CLR_ERR.
REQ-039 EMPTY, R_INC=1 -> COUNT remains 0; UNDERFLOW=1 with the macro, 0 without.
REQ-040 RST=1 with COUNT=5 while pushing -> next cycle COUNT=0, EMPTY=1, errors cleared, and the push is discarded.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and the pointer-width helper for the synchronous status FIFO.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    // One extra MSB beyond the address bits distinguishes full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: registered write port, asynchronous read port.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_stat.sv
// Synchronous FIFO with occupancy count, almost-full/empty flags and optional
// sticky overflow/underflow flags (enabled by defining SYNC_FIFO_ERR_EN).
module sync_fifo_stat
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int PW         = ptr_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  w_inc_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  r_inc_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [PW-1:0]         count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [PW-1:0] count;
    logic          push_ok, pop_ok;

    // Modular subtraction handles pointer wrap via the extra MSB.
    assign count          = w_ptr_q - r_ptr_q;
    assign count_o        = count;
    assign full_o         = (count == FULL_CNT);
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= AF_CNT);
    assign almost_empty_o = (count <= AE_CNT);

    assign push_ok = w_inc_i && !full_o;
    assign pop_ok  = r_inc_i && !empty_o;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (push_ok) w_ptr_d = w_ptr_q + 1'b1;
        if (pop_ok)  r_ptr_d = r_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (push_ok && !rst_i),
        .waddr_i(w_ptr_q[AW-1:0]),
        .wdata_i(wr_data_i),
        .raddr_i(r_ptr_q[AW-1:0]),
        .rdata_o(rd_data_o)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A set event in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q && !clr_err_i;
        unf_d = unf_q && !clr_err_i;
        if (w_inc_i && full_o)  ovf_d = 1'b1;
        if (r_inc_i && empty_o) unf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_stat.sv
// Self-checking bench for sync_fifo_stat: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_sync_fifo_stat;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_inc = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          r_inc = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rd_data;
    logic          full, empty, afull, aempty, ovf, unf;
    logic [PW-1:0] count;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_stat #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .w_inc_i       (w_inc),
        .wr_data_i     (wr_data),
        .r_inc_i       (r_inc),
        .clr_err_i     (clr_err),
        .rd_data_o     (rd_data),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (afull),
        .almost_empty_o(aempty),
        .count_o       (count),
        .overflow_o    (ovf),
        .underflow_o   (unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("count",  32'(count),  32'(n));
        chk("full",   32'(full),   32'(n == DEPTH));
        chk("empty",  32'(empty),  32'(n == 0));
        chk("afull",  32'(afull),  32'(n >= DEPTH - 2));
        chk("aempty", 32'(aempty), 32'(n <= 2));
        chk("ovf",    32'(ovf),    32'(m_ovf));
        chk("unf",    32'(unf),    32'(m_unf));
        if (n > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    endtask

    // Drive one cycle, advance the model using pre-edge occupancy, then check.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic clr, input logic rs);
        int  n     = q.size();
        bit  m_full = (n == DEPTH);
        bit  m_emp  = (n == 0);
        w_inc = w; wr_data = d; r_inc = r; clr_err = clr; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (r && !m_emp) void'(q.pop_front());
            if (w && !m_full) q.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
            if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
            if (w && m_full) m_ovf = 1'b1;
            if (r && m_emp)  m_unf = 1'b1;
`endif
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        // Fill with 0x01..0x08, head stays 0x01
        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0);
        chk("full_after_fill", 32'(full), 32'd1);
        chk("head_after_fill", 32'(rd_data), 32'h01);
        // Drain, data comes out in order
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            step(0, 8'h00, 1, 0, 0);
        end
        chk("empty_after_drain", 32'(empty), 32'd1);
        // Occupancy 4 then 20 simultaneous push/pop cycles, wrapping both pointers
        for (int i = 0; i < 4; i++) step(1, DW'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, DW'($urandom), 1, 0, 0);
        chk("count_steady", 32'(count), 32'd4);
        // Full with push+pop: pop accepted, push rejected
        for (int i = 0; i < 4; i++) step(1, DW'($urandom), 0, 0, 0);
        step(1, 8'hAA, 1, 0, 0);
        chk("count_full_pp", 32'(count), 32'd7);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        // Overflow set coinciding with clear keeps flag set
        step(1, 8'h55, 0, 0, 0);
        step(1, 8'h66, 0, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        // Drain then pop on empty
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(1, 8'h77, 1, 0, 0);
        chk("count_empty_pp", 32'(count), 32'd1);
        step(0, 8'h00, 0, 1, 0);
        // Reset mid-stream at count 5 while pushing
        for (int i = 0; i < 4; i++) step(1, DW'($urandom), 0, 0, 0);
        chk("count_pre_rst", 32'(count), 32'd5);
        step(1, 8'hEE, 1, 0, 1);
        chk("count_post_rst", 32'(count), 32'd0);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 55), DW'($urandom),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 59) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
